window_center_pass_thru: RTL and testbench

//  Parametrised delay line that re-times the raw pixel stream to the centre tap of a
//  WIN x WIN filter window, so a filter output can be blended with or replaced by the

---
 rtl/window_center_pass_thru_pkg.sv | 27 ++
 rtl/window_center_pass_thru_line_buf.sv | 25 ++
 rtl/window_center_pass_thru.sv | 125 ++++++++++++
 tb/tb_window_center_pass_thru.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_center_pass_thru_pkg.sv
// Shared constants and helpers for the window centre-tap delay line.
package win_pkg;

  localparam int PIX_W_DEF  = 24;   // RGB888
  localparam int LINE_W_DEF = 640;  // active pixels per line
  localparam int ADR_W_DEF  = 10;   // 2**10 >= 640
  localparam int WIN_DEF    = 5;

  // Output selection, loaded only on a valid start-of-frame.
  typedef enum logic {
    MODE_FILTER = 1'b0,
    MODE_BYPASS = 1'b1
  } mode_e;

  // Distance from the window edge to its centre tap.
  function automatic int half_of(input int win);
    return (win - 1) / 2;
  endfunction

  // Valid samples between a pixel entering and it reaching the centre tap.
  function automatic int delay_of(input int line_w, input int win);
    return half_of(win) * line_w + half_of(win);
  endfunction

  localparam int DELAY_DEF = (WIN_DEF - 1) / 2 * LINE_W_DEF + (WIN_DEF - 1) / 2;

endpackage

// File: rtl/window_center_pass_thru_line_buf.sv
// One line of pixel storage: single-port, read-before-write, registered read.
module line_buf #(
  parameter int PIX_W  = 24,
  parameter int LINE_W = 640,
  parameter int ADR_W  = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [ADR_W-1:0] addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [LINE_W];

  // Return the old word at addr and overwrite it with din, only on enabled cycles.
  // NOTE: no reset on the array or its read register, so the tools can map it to block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      dout      <= mem[addr];
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/window_center_pass_thru.sv
// Re-times the raw pixel stream to the centre tap of a WIN x WIN window, with
// valid gating, SOF resync, output valid, border flag and a zero-delay bypass.
//
// The line buffers are cascaded through their registered read ports: stage k
// stores the word stage k-1 read on the previous valid sample. Each stage
// therefore adds LINE_W+1 samples of delay. After HALF stages, the last stage
// holds the pixel from HALF*LINE_W + HALF - 1 samples back. The output register
// adds the final sample of the HALF-sample horizontal delay.
module window_center_pass_thru
  import win_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int WIN    = WIN_DEF,
  parameter int ADR_W  = ADR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             sof,
  input  logic             bypass,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] pix_out,
  output logic             out_valid,
  output logic             border
);

  localparam int HALF   = half_of(WIN);
  localparam int D      = delay_of(LINE_W, WIN);
  localparam int FILL_W = $clog2(D + 1);
  localparam int Y_W    = 13;

  logic                        start;
  logic [ADR_W-1:0]            in_x, cur_x, nxt_x, cx;
  logic [Y_W-1:0]              in_y, cur_y, nxt_y;
  logic [FILL_W-1:0]           fill_cnt, fill_base;
  mode_e                       bypass_q, mode_next;
  logic                        borrow, cy_top, border_next;
  logic [HALF-1:0][PIX_W-1:0]  ram_dout;

  assign start = pix_valid & sof;

  // Position of the pixel on pix_in, and the counter values that follow it.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cur_x     = start ? '0 : in_x;
    cur_y     = start ? '0 : in_y;
    fill_base = start ? '0 : fill_cnt;
    mode_next = start ? (bypass ? MODE_BYPASS : MODE_FILTER) : bypass_q;
    nxt_x     = cur_x + 1'b1;
    nxt_y     = cur_y;
    if (cur_x == ADR_W'(LINE_W - 1)) begin
      nxt_x = '0;
      nxt_y = (cur_y == {Y_W{1'b1}}) ? cur_y : cur_y + 1'b1;
    end
  end

  // Centre lies HALF pixels left and HALF rows up. It borrows a row when the
  // input is in the first HALF columns. cy < HALF is the same as
  // cur_y < 2*HALF + borrow, so cy never needs to go negative.
  always_comb begin
    borrow      = cur_x < ADR_W'(HALF);
    cx          = borrow ? cur_x + ADR_W'(LINE_W - HALF) : cur_x - ADR_W'(HALF);
    cy_top      = {1'b0, cur_y} < ((Y_W + 1)'(2 * HALF) + (Y_W + 1)'(borrow));
    border_next = (cx < ADR_W'(HALF)) | (cx > ADR_W'(LINE_W - 1 - HALF)) | cy_top;
  end

  // Line-buffer cascade: stage 0 takes the live pixel, later stages take the previous stage's read.
  for (genvar k = 0; k < HALF; k++) begin : g_line
    logic [PIX_W-1:0] ram_din;
    if (k == 0) begin : g_head
      assign ram_din = pix_in;
    end else begin : g_tail
      assign ram_din = ram_dout[k-1];
    end
    line_buf #(
      .PIX_W  (PIX_W),
      .LINE_W (LINE_W),
      .ADR_W  (ADR_W)
    ) u_line_buf (
      .clk  (clk),
      .en   (pix_valid),
      .addr (cur_x),
      .din  (ram_din),
      .dout (ram_dout[k])
    );
  end

  // Position counters, fill level and mode advance only on valid samples.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_x     <= '0;
      in_y     <= '0;
      fill_cnt <= '0;
      bypass_q <= MODE_FILTER;
    end else if (pix_valid) begin
      in_x     <= nxt_x;
      in_y     <= nxt_y;
      fill_cnt <= (fill_base == FILL_W'(D)) ? fill_base : fill_base + 1'b1;
      bypass_q <= mode_next;
    end
  end

  // Outputs: pix_out and border hold on idle cycles. out_valid waits for a
  // full delay line, so stale RAM words from an aborted frame never show up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out   <= '0;
      out_valid <= 1'b0;
      border    <= 1'b0;
    end else if (!pix_valid) begin
      out_valid <= 1'b0;
    end else if (mode_next == MODE_BYPASS) begin
      pix_out   <= pix_in;
      out_valid <= 1'b1;
      border    <= 1'b0;
    end else begin
      pix_out   <= ram_dout[HALF-1];
      out_valid <= (fill_base == FILL_W'(D));
      border    <= border_next;
    end
  end

endmodule

// File: tb/tb_window_center_pass_thru.sv
// Directed bench for window_center_pass_thru at LINE_W=8, WIN=5 (HALF=2, D=18).
module tb_window_center_pass_thru;

  localparam int PIX_W  = 24;
  localparam int LINE_W = 8;
  localparam int WIN    = 5;
  localparam int ADR_W  = 3;
  localparam int D      = 18;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pix_valid = 1'b0;
  logic             sof = 1'b0;
  logic             bypass = 1'b0;
  logic [PIX_W-1:0] pix_in = '0;
  logic [PIX_W-1:0] pix_out;
  logic             out_valid;
  logic             border;

  int n_checks = 0;
  int n_fail   = 0;

  window_center_pass_thru #(
    .PIX_W  (PIX_W),
    .LINE_W (LINE_W),
    .WIN    (WIN),
    .ADR_W  (ADR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .sof       (sof),
    .bypass    (bypass),
    .pix_in    (pix_in),
    .pix_out   (pix_out),
    .out_valid (out_valid),
    .border    (border)
  );

  always #5 clk = ~clk;

  // Present one input cycle, then sample the registered result 1 ns after the edge.
  task automatic drive(input logic v, input logic s, input logic b, input logic [PIX_W-1:0] p);
    pix_valid = v;
    sof       = s;
    bypass    = b;
    pix_in    = p;
    @(posedge clk);
    #1;
  endtask

  // Border rule for an 8-wide frame, indexed by the ramp value of the centre pixel.
  function automatic logic exp_border(input int p);
    return ((p % LINE_W) < 2) || ((p % LINE_W) > 5) || ((p / LINE_W) < 2);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({pix_out, out_valid, border} !== {{PIX_W{1'b0}}, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: pix_out=%h out_valid=%b border=%b, want 0/0/0", pix_out, out_valid, border);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, i == 0, 1'b0, PIX_W'(i));
      n_checks++;
      if (out_valid !== (i >= D)) begin
        n_fail++;
        $display("FAIL ramp_valid[%0d]: got %b want %b", i, out_valid, i >= D);
      end
      if (i >= D) begin
        n_checks++;
        if (pix_out !== PIX_W'(i - D)) begin
          n_fail++;
          $display("FAIL ramp_pix[%0d]: got %0d want %0d", i, pix_out, i - D);
        end
        n_checks++;
        if (border !== exp_border(i - D)) begin
          n_fail++;
          $display("FAIL ramp_border[%0d] centre=(%0d,%0d): got %b want %b",
                   i, (i - D) % LINE_W, (i - D) / LINE_W, border, exp_border(i - D));
        end
      end
    end
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, i == 0, 1'b0, PIX_W'(i));
      n_checks++;
      if (out_valid !== (i >= D)) begin
        n_fail++;
        $display("FAIL gap_valid[%0d]: got %b want %b", i, out_valid, i >= D);
      end
      if (i >= D) begin
        n_checks++;
        if (pix_out !== PIX_W'(i - D)) begin
          n_fail++;
          $display("FAIL gap_pix[%0d]: got %0d want %0d", i, pix_out, i - D);
        end
      end
      drive(1'b0, 1'b0, 1'b0, {PIX_W{1'b1}});
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_idle_valid[%0d]: got %b want 0", i, out_valid);
      end
      if (i >= D) begin
        n_checks++;
        if (pix_out !== PIX_W'(i - D) || border !== exp_border(i - D)) begin
          n_fail++;
          $display("FAIL gap_idle_hold[%0d]: got %0d/%b want %0d/%b",
                   i, pix_out, border, i - D, exp_border(i - D));
        end
      end
    end
  endtask

  task automatic test_mid_sof();
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, i == 0, 1'b0, PIX_W'(100 + i));
      if (i >= D) begin
        n_checks++;
        if (out_valid !== 1'b1 || pix_out !== PIX_W'(100 + i - D)) begin
          n_fail++;
          $display("FAIL midsof_first[%0d]: got %b/%0d want 1/%0d", i, out_valid, pix_out, 100 + i - D);
        end
      end
    end
    for (int j = 0; j < 30; j++) begin
      drive(1'b1, j == 0, 1'b0, PIX_W'(200 + j));
      n_checks++;
      if (out_valid !== (j >= D)) begin
        n_fail++;
        $display("FAIL midsof_valid[%0d]: got %b want %b", j, out_valid, j >= D);
      end
      if (j >= D) begin
        n_checks++;
        if (pix_out !== PIX_W'(200 + j - D)) begin
          n_fail++;
          $display("FAIL midsof_pix[%0d]: got %0d want %0d", j, pix_out, 200 + j - D);
        end
      end
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 1'b1, 24'hABCDEF);
    n_checks++;
    if ({pix_out, out_valid, border} !== {24'hABCDEF, 2'b10}) begin
      n_fail++;
      $display("FAIL bypass_sof: got %h/%b/%b want abcdef/1/0", pix_out, out_valid, border);
    end
    // bypass dropping without a SOF must not leave bypass mode
    drive(1'b1, 1'b0, 1'b0, 24'h123456);
    n_checks++;
    if ({pix_out, out_valid, border} !== {24'h123456, 2'b10}) begin
      n_fail++;
      $display("FAIL bypass_hold_mode: got %h/%b/%b want 123456/1/0", pix_out, out_valid, border);
    end
    drive(1'b0, 1'b0, 1'b0, 24'h777777);
    n_checks++;
    if ({pix_out, out_valid} !== {24'h123456, 1'b0}) begin
      n_fail++;
      $display("FAIL bypass_idle: got %h/%b want 123456/0", pix_out, out_valid);
    end
    // a SOF with bypass low returns to the delayed path
    drive(1'b1, 1'b1, 1'b0, 24'h000042);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_exit: out_valid got %b want 0", out_valid);
    end
    // bypass raised without a SOF must not enter bypass mode
    drive(1'b1, 1'b0, 1'b1, 24'h000043);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_no_sof: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    drive(1'b1, 1'b1, 1'b1, 24'h00AA55);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, PIX_W'(24'h010203 + i));
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pix_out, out_valid, border} !== {{PIX_W{1'b0}}, 2'b00}) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%b/%b want 0/0/0", pix_out, out_valid, border);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i == 0, 1'b0, PIX_W'(50 + i));
      n_checks++;
      if (out_valid !== (i >= D)) begin
        n_fail++;
        $display("FAIL post_reset_valid[%0d]: got %b want %b", i, out_valid, i >= D);
      end
      if (i >= D) begin
        n_checks++;
        if (pix_out !== PIX_W'(50 + i - D)) begin
          n_fail++;
          $display("FAIL post_reset_pix[%0d]: got %0d want %0d", i, pix_out, 50 + i - D);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gapped();
    test_mid_sof();
    test_bypass();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
